// File: rtl/img_ram_rsize_line_fetch_pkg.sv
// Shared definitions for the vertical-resize line table consumer: frame
// geometry defaults, fixed-point layout of a table entry and the FSM states.
package img_ram_rsize_line_fetch_pkg;

    localparam int OUT_LINES = 1080;
    localparam int SRC_LINES = 480;
    localparam int ADDR_W    = 11;

    // org_h is unsigned 10.5 fixed point
    localparam int FRAC_W  = 5;
    localparam int INT_W   = 10;
    localparam int ORG_H_W = INT_W + FRAC_W;

    // Table entry layout {vld, org_h}
    localparam int ENTRY_W       = ORG_H_W + 1;
    localparam int ENTRY_VLD_BIT = 15;
    localparam int ORG_H_MSB     = 14;
    localparam int ORG_H_LSB     = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_TBL,
        ST_WAIT_TBL,
        ST_CALC,
        ST_REQ,
        ST_WAIT_DONE,
        ST_DONE
    } line_state_t;

endpackage

// File: rtl/img_row_round_clamp.sv
// Converts a 10.5 fixed-point source position into an integer source row:
// optional round-to-nearest on the first fractional bit, then clamp to the
// last row of the source image.
module img_row_round_clamp #(
    parameter int ROUND_EN  = 1,
    parameter int SRC_LINES = img_ram_rsize_line_fetch_pkg::SRC_LINES
) (
    input  logic [14:0] org_h_i,
    output logic [9:0]  row_o
);
    import img_ram_rsize_line_fetch_pkg::*;

    localparam logic [10:0] ROW_MAX = 11'(SRC_LINES - 1);

    logic        round_up;
    logic [10:0] sum;

    // Sum is one bit wider than the row so 1023 + 1 still clamps correctly
    always_comb begin
        round_up = (ROUND_EN != 0) && org_h_i[FRAC_W-1];
        sum      = {1'b0, org_h_i[ORG_H_W-1:FRAC_W]} + {10'd0, round_up};
        row_o    = (sum > ROW_MAX) ? ROW_MAX[9:0] : sum[9:0];
    end

endmodule

// File: rtl/img_ram_rsize_line_fetch.sv
// Per output line: read the resize table entry, turn it into a source row,
// and either report the line blank, reuse the buffered row, or request the
// row from the frame-buffer line fetcher and wait for it to land.
module img_ram_rsize_line_fetch #(
    parameter int OUT_LINES = img_ram_rsize_line_fetch_pkg::OUT_LINES,
    parameter int SRC_LINES = img_ram_rsize_line_fetch_pkg::SRC_LINES,
    parameter int ADDR_W    = img_ram_rsize_line_fetch_pkg::ADDR_W,
    parameter int ROUND_EN  = 1,
    parameter int REUSE_EN  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_frame_start,
    input  logic              i_line_start,
    output logic [ADDR_W-1:0] o_h_ram_raddr,
    output logic              o_h_ram_re,
    input  logic              i_org_h_vld,
    input  logic [14:0]       i_org_h,
    input  logic              i_h_ram_vld,
    output logic              o_row_req,
    output logic [9:0]        o_row_addr,
    input  logic              i_row_ack,
    input  logic              i_row_done,
    output logic              o_line_rdy,
    output logic              o_line_blank,
    output logic              o_line_reuse,
    output logic              o_overrun
);
    import img_ram_rsize_line_fetch_pkg::*;

    localparam logic [ADDR_W-1:0] LINE_LIMIT = ADDR_W'(OUT_LINES);

    line_state_t          state_q;
    logic [ADDR_W-1:0]    line_cnt_q;
    logic [ADDR_W-1:0]    raddr_q;
    logic                 re_q;
    logic [ENTRY_W-1:0]   entry_q;
    logic [9:0]           last_row_q;
    logic                 last_vld_q;
    logic                 row_req_q;
    logic [9:0]           row_addr_q;
    logic                 line_rdy_q;
    logic                 blank_q;
    logic                 reuse_q;
    logic                 overrun_q;
    logic [9:0]           calc_row;

    img_row_round_clamp #(
        .ROUND_EN  (ROUND_EN),
        .SRC_LINES (SRC_LINES)
    ) u_round_clamp (
        .org_h_i (entry_q[ORG_H_MSB:ORG_H_LSB]),
        .row_o   (calc_row)
    );

    // Line FSM with registered outputs; frame start overrides everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            line_cnt_q <= '0;
            raddr_q    <= '0;
            re_q       <= 1'b0;
            entry_q    <= '0;
            last_row_q <= '0;
            last_vld_q <= 1'b0;
            row_req_q  <= 1'b0;
            row_addr_q <= '0;
            line_rdy_q <= 1'b0;
            blank_q    <= 1'b0;
            reuse_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            re_q       <= 1'b0;
            line_rdy_q <= 1'b0;
            blank_q    <= 1'b0;
            reuse_q    <= 1'b0;
            overrun_q  <= 1'b0;

            if (i_frame_start) begin
                line_cnt_q <= '0;
                last_vld_q <= 1'b0;
                row_req_q  <= 1'b0;
                if (i_line_start) begin
                    state_q <= ST_RD_TBL;
                    re_q    <= 1'b1;
                    raddr_q <= '0;
                end else begin
                    state_q <= ST_IDLE;
                end
            end else begin
                if (i_line_start && (state_q != ST_IDLE)) begin
                    overrun_q <= 1'b1;
                end

                case (state_q)
                    ST_IDLE: begin
                        if (i_line_start) begin
                            if (line_cnt_q == LINE_LIMIT) begin
                                overrun_q <= 1'b1;
                            end else begin
                                state_q <= ST_RD_TBL;
                                re_q    <= 1'b1;
                                raddr_q <= line_cnt_q;
                            end
                        end
                    end
                    ST_RD_TBL: begin
                        state_q <= ST_WAIT_TBL;
                    end
                    ST_WAIT_TBL: begin
                        if (i_h_ram_vld) begin
                            entry_q <= {i_org_h_vld, i_org_h};
                            state_q <= ST_CALC;
                        end
                    end
                    ST_CALC: begin
                        if (!entry_q[ENTRY_VLD_BIT]) begin
                            state_q    <= ST_DONE;
                            line_rdy_q <= 1'b1;
                            blank_q    <= 1'b1;
                        end else if ((REUSE_EN != 0) && last_vld_q && (calc_row == last_row_q)) begin
                            state_q    <= ST_DONE;
                            line_rdy_q <= 1'b1;
                            reuse_q    <= 1'b1;
                        end else begin
                            state_q    <= ST_REQ;
                            row_req_q  <= 1'b1;
                            row_addr_q <= calc_row;
                        end
                    end
                    ST_REQ: begin
                        if (i_row_ack) begin
                            row_req_q  <= 1'b0;
                            last_row_q <= row_addr_q;
                            last_vld_q <= 1'b1;
                            if (i_row_done) begin
                                state_q    <= ST_DONE;
                                line_rdy_q <= 1'b1;
                            end else begin
                                state_q <= ST_WAIT_DONE;
                            end
                        end
                    end
                    ST_WAIT_DONE: begin
                        if (i_row_done) begin
                            state_q    <= ST_DONE;
                            line_rdy_q <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        state_q    <= ST_IDLE;
                        line_cnt_q <= line_cnt_q + ADDR_W'(1);
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_h_ram_raddr = raddr_q;
    assign o_h_ram_re    = re_q;
    assign o_row_req     = row_req_q;
    assign o_row_addr    = row_addr_q;
    assign o_line_rdy    = line_rdy_q;
    assign o_line_blank  = blank_q;
    assign o_line_reuse  = reuse_q;
    assign o_overrun     = overrun_q;

endmodule

// File: tb/tb_img_ram_rsize_line_fetch.sv
// Directed bench for the resize line fetcher: a behavioural table RAM returns
// entries one cycle after each read, and the fetch handshake is driven by hand.
module tb_img_ram_rsize_line_fetch;

    localparam int KBLANK = 0;
    localparam int KREUSE = 1;
    localparam int KFETCH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_frame_start;
    logic        i_line_start;
    logic [10:0] o_h_ram_raddr;
    logic        o_h_ram_re;
    logic        i_org_h_vld;
    logic [14:0] i_org_h;
    logic        i_h_ram_vld;
    logic        o_row_req;
    logic [9:0]  o_row_addr;
    logic        i_row_ack;
    logic        i_row_done;
    logic        o_line_rdy;
    logic        o_line_blank;
    logic        o_line_reuse;
    logic        o_overrun;

    logic [15:0] tbl [0:2047];
    logic        reSeen   = 1'b0;
    logic [10:0] addrSeen = '0;

    logic [14:0] orgHTest;
    logic [9:0]  rowRound;
    logic [9:0]  rowTrunc;

    int          checks = 0;
    int          errors = 0;
    logic [10:0] lineIdx;

    always #5 clk = ~clk;

    img_ram_rsize_line_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .i_frame_start (i_frame_start),
        .i_line_start  (i_line_start),
        .o_h_ram_raddr (o_h_ram_raddr),
        .o_h_ram_re    (o_h_ram_re),
        .i_org_h_vld   (i_org_h_vld),
        .i_org_h       (i_org_h),
        .i_h_ram_vld   (i_h_ram_vld),
        .o_row_req     (o_row_req),
        .o_row_addr    (o_row_addr),
        .i_row_ack     (i_row_ack),
        .i_row_done    (i_row_done),
        .o_line_rdy    (o_line_rdy),
        .o_line_blank  (o_line_blank),
        .o_line_reuse  (o_line_reuse),
        .o_overrun     (o_overrun)
    );

    img_row_round_clamp #(.ROUND_EN(1), .SRC_LINES(480)) uRound (
        .org_h_i (orgHTest),
        .row_o   (rowRound)
    );

    img_row_round_clamp #(.ROUND_EN(0), .SRC_LINES(480)) uTrunc (
        .org_h_i (orgHTest),
        .row_o   (rowTrunc)
    );

    // Table RAM model: a read seen in one cycle returns its entry the next
    always @(posedge clk) begin
        #1;
        i_h_ram_vld = reSeen;
        i_org_h_vld = tbl[addrSeen][15];
        i_org_h     = tbl[addrSeen][14:0];
        reSeen      = o_h_ram_re;
        addrSeen    = o_h_ram_raddr;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One output line from line_start through the ready pulse
    task automatic applyStimulus(input logic withFrame, input int kind, input logic [9:0] expRow,
                                 input int ackDelay, input logic doneWithAck);
        logic holdOk;
        i_frame_start = withFrame;
        i_line_start  = 1'b1;
        tick();
        i_frame_start = 1'b0;
        i_line_start  = 1'b0;
        checkOutput("re", o_h_ram_re, 1);
        checkOutput("raddr", o_h_ram_raddr, lineIdx);
        tick();
        tick();
        tick();
        if (kind != KFETCH) begin
            checkOutput("rdyShort", o_line_rdy, 1);
            checkOutput("blank", o_line_blank, kind == KBLANK);
            checkOutput("reuse", o_line_reuse, kind == KREUSE);
            checkOutput("noReq", o_row_req, 0);
        end else begin
            checkOutput("req", o_row_req, 1);
            checkOutput("rowAddr", o_row_addr, expRow);
            checkOutput("rdyEarly", o_line_rdy, 0);
            holdOk = 1'b1;
            for (int i = 0; i < ackDelay; i++) begin
                tick();
                if (o_row_req !== 1'b1 || o_row_addr !== expRow) holdOk = 1'b0;
            end
            if (ackDelay > 0) checkOutput("reqHold", holdOk, 1);
            i_row_ack  = 1'b1;
            i_row_done = doneWithAck;
            tick();
            i_row_ack  = 1'b0;
            i_row_done = 1'b0;
            checkOutput("reqDrop", o_row_req, 0);
            if (!doneWithAck) begin
                checkOutput("rdyWait", o_line_rdy, 0);
                i_row_done = 1'b1;
                tick();
                i_row_done = 1'b0;
            end
            checkOutput("rdyFetch", o_line_rdy, 1);
            checkOutput("fetchBlank", o_line_blank, 0);
            checkOutput("fetchReuse", o_line_reuse, 0);
        end
        tick();
        checkOutput("rdyPulse", o_line_rdy, 0);
        lineIdx++;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL timeout observed running expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        for (int i = 0; i < 2048; i++) tbl[i] = 16'h0000;
        rst = 1'b1;
        i_frame_start = 1'b0;
        i_line_start  = 1'b0;
        i_row_ack     = 1'b0;
        i_row_done    = 1'b0;
        orgHTest      = 15'h0000;
        lineIdx       = '0;

        // Rounding/clamp unit on its own, both rounding modes
        orgHTest = 15'h00C8; #1;
        checkOutput("rnd6.8", rowRound, 6);
        checkOutput("trunc6.8", rowTrunc, 6);
        orgHTest = 15'h00D0; #1;
        checkOutput("rnd6.16", rowRound, 7);
        checkOutput("trunc6.16", rowTrunc, 6);
        orgHTest = 15'h3BF0; #1;
        checkOutput("rnd479.16", rowRound, 479);
        checkOutput("trunc479.16", rowTrunc, 479);
        orgHTest = 15'h7FFF; #1;
        checkOutput("rndMax", rowRound, 479);

        repeat (3) tick();
        checkOutput("rstRe", o_h_ram_re, 0);
        checkOutput("rstReq", o_row_req, 0);
        checkOutput("rstRdy", o_line_rdy, 0);
        checkOutput("rstOver", o_overrun, 0);
        checkOutput("rstRaddr", o_h_ram_raddr, 0);
        rst = 1'b0;
        tick();

        tbl[0] = 16'h8060;
        tbl[1] = 16'h8064;
        tbl[2] = 16'h80C8;
        tbl[3] = 16'h80D0;
        tbl[4] = 16'h00D0;
        tbl[5] = 16'h80E0;
        tbl[6] = 16'hCB00;
        tbl[7] = 16'h8140;
        tbl[8] = 16'h8180;

        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;

        applyStimulus(1'b0, KFETCH, 10'd3, 1, 1'b0);
        applyStimulus(1'b0, KREUSE, 10'd0, 0, 1'b0);
        applyStimulus(1'b0, KFETCH, 10'd6, 0, 1'b1);
        applyStimulus(1'b0, KFETCH, 10'd7, 2, 1'b0);
        applyStimulus(1'b0, KBLANK, 10'd0, 0, 1'b0);
        applyStimulus(1'b0, KREUSE, 10'd0, 0, 1'b0);
        applyStimulus(1'b0, KFETCH, 10'd479, 20, 1'b0);

        // Line 7: line_start while waiting for the fetcher is rejected
        i_line_start = 1'b1;
        tick();
        i_line_start = 1'b0;
        tick(); tick(); tick();
        checkOutput("l7req", o_row_req, 1);
        checkOutput("l7addr", o_row_addr, 10);
        i_row_ack = 1'b1;
        tick();
        i_row_ack = 1'b0;
        i_line_start = 1'b1;
        tick();
        i_line_start = 1'b0;
        checkOutput("l7overrun", o_overrun, 1);
        checkOutput("l7noRe", o_h_ram_re, 0);
        i_row_done = 1'b1;
        tick();
        i_row_done = 1'b0;
        checkOutput("l7overrunEnd", o_overrun, 0);
        checkOutput("l7rdy", o_line_rdy, 1);
        tick();

        // Line 8: frame restart while the request is pending
        i_line_start = 1'b1;
        tick();
        i_line_start = 1'b0;
        tick(); tick(); tick();
        checkOutput("l8req", o_row_req, 1);
        checkOutput("l8addr", o_row_addr, 12);
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
        checkOutput("abortReq", o_row_req, 0);
        checkOutput("abortRdy", o_line_rdy, 0);
        i_row_done = 1'b1;
        tick();
        i_row_done = 1'b0;
        checkOutput("lateDoneRdy", o_line_rdy, 0);
        tick();
        checkOutput("lateDoneRdy2", o_line_rdy, 0);
        checkOutput("lateDoneRe", o_h_ram_re, 0);

        // New frame with simultaneous line start: row 3 must be fetched again
        lineIdx = '0;
        applyStimulus(1'b1, KFETCH, 10'd3, 0, 1'b1);

        // Full frame of blank lines, then one too many
        for (int i = 0; i < 2048; i++) tbl[i] = 16'h0000;
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
        lineIdx = '0;
        for (int i = 0; i < 1080; i++) applyStimulus(1'b0, KBLANK, 10'd0, 0, 1'b0);
        i_line_start = 1'b1;
        tick();
        i_line_start = 1'b0;
        checkOutput("endOverrun", o_overrun, 1);
        checkOutput("endNoRe", o_h_ram_re, 0);
        tick();
        checkOutput("endNoRe2", o_h_ram_re, 0);
        checkOutput("endOverrunPulse", o_overrun, 0);

        // Reset while a request is outstanding
        tbl[0] = 16'h80A0;
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
        i_line_start = 1'b1;
        tick();
        i_line_start = 1'b0;
        tick(); tick(); tick();
        checkOutput("preRstReq", o_row_req, 1);
        checkOutput("preRstAddr", o_row_addr, 5);
        rst = 1'b1;
        tick();
        checkOutput("midRstReq", o_row_req, 0);
        checkOutput("midRstAddr", o_row_addr, 0);
        checkOutput("midRstRe", o_h_ram_re, 0);
        checkOutput("midRstRdy", o_line_rdy, 0);
        checkOutput("midRstBlank", o_line_blank, 0);
        checkOutput("midRstReuse", o_line_reuse, 0);
        checkOutput("midRstOver", o_overrun, 0);
        checkOutput("midRstRaddr", o_h_ram_raddr, 0);
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
